// File: rtl/crossyroad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossyroad_pkg
// Brief    : Shared types and constants for the crossyroad move input path.
//            Move direction encoding, button bit indices and the default
//            debounce length.
// Revision : 1.0 - initial release
// ============================================================================
package crossyroad_pkg;

  typedef enum logic [1:0] {
    MOVE_UP    = 2'b00,
    MOVE_DOWN  = 2'b01,
    MOVE_LEFT  = 2'b10,
    MOVE_RIGHT = 2'b11
  } move_dir_t;

  // Bit positions of each direction in the raw button bus
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // 10 ms at a 25 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage
`default_nettype wire

// File: rtl/move_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : move_input_ctrl_if
// Brief    : Valid/ready move-token channel between the input front end
//            (master) and the game core (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface move_input_ctrl_if;
  import crossyroad_pkg::*;

  logic      move_valid;
  logic      move_ready;
  move_dir_t move_dir;

  modport master (
    output move_valid,
    output move_dir,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : One button: 2-flop synchronizer, debounce counter and a
//            registered one-cycle press pulse on each debounced 0->1 edge.
//            Optional macro MOVE_REPEAT_EN adds hold-to-repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2
`ifdef MOVE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync_meta;
  logic             sync_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press_q;
  logic             mismatch;
  logic             flip;
  logic             repeat_fire;

  assign mismatch = (sync_q != stable);
  // The counter already holds DEBOUNCE_CYCLES-1 mismatched samples, so this
  // edge is the DEBOUNCE_CYCLES-th consecutive one: accept the new level.
  assign flip     = mismatch && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

`ifdef MOVE_REPEAT_EN
  logic [31:0] hold_cnt;
  logic        repeating;

  assign repeat_fire = stable &&
    (hold_cnt == (repeating ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));

  // Hold timer: runs while debounced high, first fires after the initial delay
  always_ff @(posedge clk) begin
    if (rst || !stable) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (repeat_fire) begin
      hold_cnt  <= '0;
      repeating <= 1'b1;
    end else begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // Synchronizer, debounce counter, stable level and press pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_meta <= btn_async;
      sync_q    <= sync_meta;
      press_q   <= (flip && sync_q) || repeat_fire;
      if (!mismatch) begin
        cnt <= '0;
      end else if (flip) begin
        cnt    <= '0;
        stable <= sync_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/move_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_input_ctrl
// Brief    : Crossyroad move input front end. Debounces four direction
//            buttons, turns each press into a move token (up > down > left >
//            right when simultaneous) and queues tokens in a small FIFO
//            drained over a valid/ready channel. Sticky overflow on drop.
//            Optional macro MOVE_REPEAT_EN enables hold-to-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module move_input_ctrl
  import crossyroad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = 4
`ifdef MOVE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  input  logic [3:0]                  btn_in,
  move_input_ctrl_if.master           move,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    press;
  logic          push;
  move_dir_t     push_dir;

  move_dir_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          valid;
  logic          full;
  logic          do_push;
  logic          do_pop;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef MOVE_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_btn (
      .clk       (clk),
      .rst       (sys_rst),
      .btn_async (btn_in[i]),
      .press     (press[i])
    );
  end

  // Pick the single highest-priority press; the rest are silently discarded
  always_comb begin
    push     = 1'b0;
    push_dir = MOVE_UP;
    if (press[BTN_UP]) begin
      push     = 1'b1;
      push_dir = MOVE_UP;
    end else if (press[BTN_DOWN]) begin
      push     = 1'b1;
      push_dir = MOVE_DOWN;
    end else if (press[BTN_LEFT]) begin
      push     = 1'b1;
      push_dir = MOVE_LEFT;
    end else if (press[BTN_RIGHT]) begin
      push     = 1'b1;
      push_dir = MOVE_RIGHT;
    end
  end

  assign valid   = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = valid && move.move_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  // Token storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dir;
  end

  assign move.move_valid = valid;
  assign move.move_dir   = valid ? mem[rd_ptr] : MOVE_UP;
  assign fifo_count      = count;
  assign overflow        = overflow_q;

endmodule
`default_nettype wire
